// File: rtl/axi4s_frame_ctrl_pkg.sv
// axi4s_frame_ctrl_pkg: shared FSM state encoding, err bit positions and a counter-width helper.
package axi4s_frame_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int ERR_EARLY_TLAST = 0;
  localparam int ERR_LATE_TLAST  = 1;
  localparam int ERR_DROP_SOF    = 2;
  localparam int ERR_TIMEOUT     = 3;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi4s_frame_ctrl_if.sv
// axi4s_frame_ctrl_if: AXI4-Stream video bundle.
//   tdata/tvalid/tlast/tuser[2:0] flow master -> slave, tready flows slave -> master.
interface axi4s_frame_ctrl_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [2:0]            tuser;

  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/frame_pos_cnt.sv
// frame_pos_cnt: pixel (x) / line (y) position counter with end-of-line and end-of-frame flags.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_adv        : advance one pixel position
//   o_x, o_y     : current position
//   o_x_last     : x == W-1
//   o_y_last     : y == H-1
module frame_pos_cnt
  import axi4s_frame_ctrl_pkg::*;
#(
  parameter int W = 640,
  parameter int H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  output logic [cw(W)-1:0] o_x,
  output logic [cw(H)-1:0] o_y,
  output logic             o_x_last,
  output logic             o_y_last
);
  localparam int XW = cw(W);
  localparam int YW = cw(H);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_x_last = r_x == XW'(W - 1);
  assign o_y_last = r_y == YW'(H - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      r_x <= o_x_last ? '0 : r_x + XW'(1);
      if (o_x_last) r_y <= o_y_last ? '0 : r_y + YW'(1);
    end
  end
endmodule

// File: rtl/axi4s_frame_ctrl.sv
// axi4s_frame_ctrl: frame-level gatekeeper between an upstream video stream and a processing pipeline.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable, start         : level enable (blocks re-arm only), one-cycle arm pulse
//   continuous            : re-arm automatically after each frame
//   exp_out_lines         : pipeline output lines that complete a frame
//   s_axis / m_axis       : upstream video in / regenerated video out
//   p_tvalid/p_tready/p_tlast : monitor taps on the pipeline output
//   busy, frame_done      : not idle, one-cycle end-of-frame pulse
//   err, err_clr          : sticky {timeout, drop_sof, late_tlast, early_tlast}, clear pulse
//   frame_count           : completed frames, wraps at 16 bits
module axi4s_frame_ctrl
  import axi4s_frame_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int DATA_WIDTH    = 24,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [15:0]               exp_out_lines,
  axi4s_frame_ctrl_if.slave         s_axis,
  axi4s_frame_ctrl_if.master        m_axis,
  input  logic                      p_tvalid,
  input  logic                      p_tready,
  input  logic                      p_tlast,
  output logic                      busy,
  output logic                      frame_done,
  output logic [3:0]                err,
  input  logic                      err_clr,
  output logic [15:0]               frame_count
);
  localparam int XW = cw(IMAGE_WIDTH);
  localparam int YW = cw(IMAGE_HEIGHT);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  state_t                r_state, w_next;
  logic [XW-1:0]         w_x;
  logic [YW-1:0]         w_y;
  logic                  w_x_last, w_y_last;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_wait, w_fwd, w_hs, w_drop, w_p_hs, w_lines_ok, w_timeout, w_rearm;
  logic [3:0]            w_err_set;
  logic [15:0]           r_lines;
  logic [TW-1:0]         r_timer;
  logic [3:0]            r_err;
  logic [15:0]           r_fcnt;

  frame_pos_cnt #(.W(IMAGE_WIDTH), .H(IMAGE_HEIGHT)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_adv    (w_hs),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_x_last (w_x_last),
    .o_y_last (w_y_last)
  );

  // The SOF beat seen in WAIT_SOF is forwarded as beat 0 of the frame; every
  // other WAIT_SOF beat is swallowed with tready held high.
  assign w_wait   = (r_state == S_WAIT_SOF) & enable;
  assign w_fwd    = (r_state == S_ACTIVE) | (w_wait & s_axis.tuser[0]);
  assign w_data   = s_axis.tdata;
  assign w_hs     = m_axis.tvalid & m_axis.tready;
  assign w_drop   = w_wait & s_axis.tvalid & ~s_axis.tuser[0];
  assign w_p_hs   = p_tvalid & p_tready;

  assign m_axis.tdata  = w_data;
  assign m_axis.tvalid = w_fwd & s_axis.tvalid;
  assign m_axis.tlast  = w_x_last;
  assign m_axis.tuser  = {s_axis.tuser[2:1], (w_x == '0) & (w_y == '0)};
  assign s_axis.tready = w_fwd ? m_axis.tready : w_wait;

  assign w_lines_ok = r_lines >= exp_out_lines;
  // Timer value DRAIN_TIMEOUT-1 with another idle cycle means DRAIN_TIMEOUT idle cycles have elapsed.
  assign w_timeout  = (r_state == S_DRAIN) & ~w_lines_ok & ~w_p_hs & (r_timer == TW'(DRAIN_TIMEOUT - 1));
  assign w_rearm    = (w_next == S_WAIT_SOF) & (r_state != S_WAIT_SOF);

  always_comb begin
    w_err_set                  = '0;
    w_err_set[ERR_EARLY_TLAST] = w_hs & s_axis.tlast & ~w_x_last;
    w_err_set[ERR_LATE_TLAST]  = w_hs & ~s_axis.tlast & w_x_last;
    w_err_set[ERR_DROP_SOF]    = w_drop;
    w_err_set[ERR_TIMEOUT]     = w_timeout;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = (start & enable) ? S_WAIT_SOF : S_IDLE;
      S_WAIT_SOF: w_next = !enable ? S_IDLE : !w_hs ? S_WAIT_SOF : (w_x_last & w_y_last) ? S_DRAIN : S_ACTIVE;
      S_ACTIVE:   w_next = (w_hs & w_x_last & w_y_last) ? S_DRAIN : S_ACTIVE;
      S_DRAIN:    w_next = (w_lines_ok | w_timeout) ? S_DONE : S_DRAIN;
      S_DONE:     w_next = (continuous & enable) ? S_WAIT_SOF : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lines <= '0;
      r_timer <= '0;
      r_err   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_lines <= w_rearm ? '0 : r_lines + 16'((r_state != S_IDLE) & w_p_hs & p_tlast);
      r_timer <= ((r_state == S_DRAIN) & ~w_p_hs) ? r_timer + TW'(1) : '0;
      r_err   <= err_clr ? '0 : r_err | w_err_set;
      r_fcnt  <= r_fcnt + 16'(r_state == S_DONE);
    end
  end

  assign busy        = r_state != S_IDLE;
  assign frame_done  = r_state == S_DONE;
  assign err         = r_err;
  assign frame_count = r_fcnt;
endmodule

// File: tb/tb_axi4s_frame_ctrl.sv
// tb_axi4s_frame_ctrl: directed bench with a beat-index model checking every forwarded beat.
module tb_axi4s_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 24;
  localparam int TO = 16;

  logic        clk = 0, rst_n = 0, enable = 0, start = 0, continuous = 0, err_clr = 0;
  logic        p_tvalid = 0, p_tready = 0, p_tlast = 0;
  logic [15:0] exp_out_lines = 16'd2;
  logic        busy, frame_done;
  logic [3:0]  err;
  logic [15:0] frame_count;

  axi4s_frame_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
  axi4s_frame_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

  axi4s_frame_ctrl #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .continuous(continuous),
    .exp_out_lines(exp_out_lines), .s_axis(s_if), .m_axis(m_if),
    .p_tvalid(p_tvalid), .p_tready(p_tready), .p_tlast(p_tlast),
    .busy(busy), .frame_done(frame_done), .err(err), .err_clr(err_clr), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, mb = 0, dones = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: the n-th forwarded beat of a frame carries tlast when n is the last
  // pixel of a line and tuser[0] only when n is the first pixel of the frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      mb = 0;
      chk("rst_busy", busy, 0);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_frame_done", frame_done, 0);
    end else begin
      if (frame_done) dones++;
      if (m_if.tvalid && m_if.tready) begin
        chk("fwd_tdata", m_if.tdata, s_if.tdata);
        chk("fwd_tlast", m_if.tlast, (mb % W) == W - 1);
        chk("fwd_sof", m_if.tuser[0], mb == 0);
        chk("fwd_tuser_hi", m_if.tuser[2:1], s_if.tuser[2:1]);
        chk("fwd_s_tready", s_if.tready, 1);
        mb = (mb + 1) % (W * H);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic sof, input logic last, input logic [1:0] u);
    int  n  = 0;
    logic ok = 0;
    s_if.tdata  = d;
    s_if.tuser  = {u, sof};
    s_if.tlast  = last;
    s_if.tvalid = 1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", ok, 1);
    s_if.tvalid = 0;
  endtask

  task automatic send_beats(input int from, input int to, input int base, input int early,
                            input int nolast, input bit bp);
    for (int i = from; i < to; i++) begin
      if (bp && i == 1) begin
        s_if.tdata  = DW'(base + i);
        s_if.tuser  = '0;
        s_if.tlast  = 0;
        s_if.tvalid = 1;
        m_if.tready = 0;
        @(negedge clk);
        chk("bp_s_tready", s_if.tready, 0);
        chk("bp_m_tvalid", m_if.tvalid, 1);
        @(posedge clk);
        #1;
        m_if.tready = 1;
      end
      send(DW'(base + i), i == 0, ((i % W) == W - 1 && i != nolast) || i == early, 2'(i));
    end
  endtask

  task automatic p_line();
    p_tvalid = 1;
    p_tready = 1;
    p_tlast  = 1;
    tick(1);
    p_tvalid = 0;
    p_tready = 0;
    p_tlast  = 0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      if (frame_done) break;
      n++;
    end
    chk("done_seen", frame_done, 1);
    tick(1);
    chk("done_one_cycle", frame_done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, d0;
    s_if.tvalid = 0;
    s_if.tdata  = '0;
    s_if.tlast  = 0;
    s_if.tuser  = '0;
    m_if.tready = 1;
    tick(3);
    rst_n = 1;
    tick(1);
    chk("por_err", err, 0);
    chk("por_frame_count", frame_count, 0);
    chk("por_busy", busy, 0);

    // Clean frame with one backpressure stall, two pipeline lines
    enable = 1;
    pulse_start();
    chk("t1_busy", busy, 1);
    send_beats(0, 8, 'h100, -1, -1, 1);
    chk("t1_drain_s_tready", s_if.tready, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t1_done_latency", n, 1);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_err", err, 0);

    // err_clr beats a same-cycle set; enable low in WAIT_SOF returns to IDLE
    pulse_start();
    err_clr = 1;
    send('hDEAD, 0, 0, 2'b00);
    err_clr = 0;
    chk("clr_priority", err, 0);
    send('hBEEF, 0, 0, 2'b00);
    chk("drop_sets_err", err, 4'b0100);
    enable = 0;
    tick(1);
    chk("wait_sof_disable", busy, 0);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("err_clr", err, 0);
    enable = 1;

    // Two junk beats ahead of SOF
    pulse_start();
    send('h0A0A0A, 0, 0, 2'b01);
    send('h0B0B0B, 0, 1, 2'b10);
    send_beats(0, 8, 'h200, -1, -1, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t2_err", err, 4'b0100);
    chk("t2_frame_count", frame_count, 2);
    err_clr = 1;
    tick(1);
    err_clr = 0;

    // Early tlast on beat 2, missing tlast on beat 7
    pulse_start();
    send_beats(0, 8, 'h300, 2, 7, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t3_err", err, 4'b0011);
    chk("t3_frame_count", frame_count, 3);
    err_clr = 1;
    tick(1);
    err_clr = 0;

    // No pipeline output: drain timeout
    pulse_start();
    send_beats(0, 8, 'h400, -1, -1, 0);
    wait_done(40, n);
    chk("t4_timeout_cycles", n, TO);
    chk("t4_err", err, 4'b1000);
    chk("t4_frame_count", frame_count, 4);

    // Continuous: re-arms, then enable drop mid-frame lets the frame finish
    continuous = 1;
    pulse_start();
    send_beats(0, 8, 'h500, -1, -1, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t5_rearm_busy", busy, 1);
    chk("t5_frame_count_a", frame_count, 5);
    send_beats(0, 5, 'h540, -1, -1, 0);
    enable = 0;
    send_beats(5, 8, 'h540, -1, -1, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t5_idle_busy", busy, 0);
    chk("t5_frame_count_b", frame_count, 6);
    chk("t5_err_sticky", err, 4'b1000);
    continuous = 0;
    enable = 1;

    // Reset asserted at beat 5
    pulse_start();
    send_beats(0, 5, 'h600, -1, -1, 0);
    d0 = dones;
    s_if.tdata  = 'h600005;
    s_if.tuser  = '0;
    s_if.tlast  = 0;
    s_if.tvalid = 1;
    #2;
    rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_s_tready", s_if.tready, 0);
    chk("t6_m_tvalid", m_if.tvalid, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_frame_count", frame_count, 0);
    chk("t6_err", err, 0);
    tick(2);
    s_if.tvalid = 0;
    rst_n = 1;
    tick(3);
    chk("t6_no_done", dones, d0);
    chk("t6_busy_after", busy, 0);
    pulse_start();
    send_beats(0, 8, 'h700, -1, -1, 0);
    p_line();
    p_line();
    wait_done(10, n);
    chk("t6_frame_count_after", frame_count, 1);
    chk("t6_err_after", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
